// File: rtl/mem_wb_buffered_reg_pkg.sv
// MEM/WB buffered register: shared field widths and entry layout.
// Entry packs {wb_en, mem_r, alu_res, mem_res, dest}.
package mem_wb_buffered_reg_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH_DEF  = 2;
  localparam int FLAG_W     = 2;

  function automatic int entry_w(input int dw, input int aw);
    return FLAG_W + 2 * dw + aw;
  endfunction

endpackage

// File: rtl/mem_wb_buffered_reg_buf_mem.sv
// MEM/WB buffered register: entry storage.
// One write port, one asynchronous read port, no reset.
module stage_buf_mem #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Write the pushed entry into its slot
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_wb_buffered_reg.sv
// MEM/WB buffered register: small FIFO between MEM and WB stages.
// Define MEM_WB_FWD_EN to add the fwd_valid/fwd_dest/fwd_value outputs.
module mem_wb_buffered_reg
  import mem_wb_buffered_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_r_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] mem_res_in,
  input  logic [ADDR_W-1:0] dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en_out,
  output logic              mem_r_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] mem_res_out,
  output logic [ADDR_W-1:0] dest_out,
  output logic [DATA_W-1:0] wb_value_out
`ifdef MEM_WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_value
`endif
);

  localparam int ENTRY_W = entry_w(DATA_W, ADDR_W);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic               push, pop;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  logic              h_wb, h_mr;
  logic [DATA_W-1:0] h_alu, h_mem;
  logic [ADDR_W-1:0] h_dest;

  assign in_ready  = count_q < CNT_W'(DEPTH);
  assign out_valid = count_q != '0;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign wr_entry = {wb_en_in, mem_r_in, alu_res_in, mem_res_in, dest_in};

  stage_buf_mem #(
    .W    (ENTRY_W),
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr_q),
    .wdata(wr_entry),
    .raddr(rd_ptr_q),
    .rdata(rd_entry)
  );

  // Next pointers and occupancy; flush discards everything
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Present the head entry, forced to zero when empty
  always_comb begin
    {h_wb, h_mr, h_alu, h_mem, h_dest} = rd_entry;
    wb_en_out    = 1'b0;
    mem_r_out    = 1'b0;
    alu_res_out  = '0;
    mem_res_out  = '0;
    dest_out     = '0;
    wb_value_out = '0;
    if (out_valid) begin
      wb_en_out    = h_wb;
      mem_r_out    = h_mr;
      alu_res_out  = h_alu;
      mem_res_out  = h_mem;
      dest_out     = h_dest;
      wb_value_out = h_mr ? h_mem : h_alu;
    end
  end

`ifdef MEM_WB_FWD_EN
  assign fwd_valid = out_valid & wb_en_out;
  assign fwd_dest  = fwd_valid ? dest_out : '0;
  assign fwd_value = fwd_valid ? wb_value_out : '0;
`endif

endmodule

// File: tb/tb_mem_wb_buffered_reg.sv
// Bench for mem_wb_buffered_reg: queue model plus directed checks.
// Covers MEM_WB_FWD_EN outputs when that macro is defined.
module tb_mem_wb_buffered_reg;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready;
  logic          wb_en_in, mem_r_in;
  logic [DW-1:0] alu_res_in, mem_res_in;
  logic [AW-1:0] dest_in;
  logic          out_valid, out_ready;
  logic          wb_en_out, mem_r_out;
  logic [DW-1:0] alu_res_out, mem_res_out, wb_value_out;
  logic [AW-1:0] dest_out;
`ifdef MEM_WB_FWD_EN
  logic          fwd_valid;
  logic [AW-1:0] fwd_dest;
  logic [DW-1:0] fwd_value;
`endif

  mem_wb_buffered_reg #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .wb_en_in    (wb_en_in),
    .mem_r_in    (mem_r_in),
    .alu_res_in  (alu_res_in),
    .mem_res_in  (mem_res_in),
    .dest_in     (dest_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .wb_en_out   (wb_en_out),
    .mem_r_out   (mem_r_out),
    .alu_res_out (alu_res_out),
    .mem_res_out (mem_res_out),
    .dest_out    (dest_out),
    .wb_value_out(wb_value_out)
`ifdef MEM_WB_FWD_EN
    ,
    .fwd_valid   (fwd_valid),
    .fwd_dest    (fwd_dest),
    .fwd_value   (fwd_value)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wb;
    logic          mr;
    logic [DW-1:0] alu;
    logic [DW-1:0] mem;
    logic [AW-1:0] dest;
  } ent_t;

  ent_t q[$];
  ent_t nw;
  ent_t hd;
  int   checks = 0;
  int   errors = 0;
  bit   armed  = 0;
  bit   m_push, m_pop;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h",
               nm, $time, act, exp);
    end
  endtask

  // Reference: a plain FIFO of at most DEPTH entries
  always @(posedge clk) begin
    if (rst || flush) begin
      q.delete();
    end else begin
      m_push = in_valid && (q.size() < DEPTH);
      m_pop  = (q.size() != 0) && out_ready;
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        nw.wb   = wb_en_in;
        nw.mr   = mem_r_in;
        nw.alu  = alu_res_in;
        nw.mem  = mem_res_in;
        nw.dest = dest_in;
        q.push_back(nw);
      end
    end
  end

  // Compare every output against the model mid-cycle
  always @(negedge clk) begin
    if (armed) begin
      chk("m_in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      chk("m_out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        hd = q[0];
      end else begin
        hd.wb = 0; hd.mr = 0; hd.alu = 0; hd.mem = 0; hd.dest = 0;
      end
      chk("m_wb_en", 64'(wb_en_out), 64'(hd.wb));
      chk("m_mem_r", 64'(mem_r_out), 64'(hd.mr));
      chk("m_alu", 64'(alu_res_out), 64'(hd.alu));
      chk("m_mem", 64'(mem_res_out), 64'(hd.mem));
      chk("m_dest", 64'(dest_out), 64'(hd.dest));
      chk("m_value", 64'(wb_value_out),
          64'(hd.mr ? hd.mem : hd.alu));
`ifdef MEM_WB_FWD_EN
      chk("m_fwd_valid", 64'(fwd_valid), 64'(hd.wb));
      chk("m_fwd_dest", 64'(fwd_dest), 64'(hd.wb ? hd.dest : '0));
      chk("m_fwd_value", 64'(fwd_value),
          64'(hd.wb ? (hd.mr ? hd.mem : hd.alu) : '0));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wb, input logic mr,
                       input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                       input logic [AW-1:0] d);
    in_valid   = v;
    wb_en_in   = wb;
    mem_r_in   = mr;
    alu_res_in = alu;
    mem_res_in = mem;
    dest_in    = d;
  endtask

  initial begin
    rst = 1; flush = 0; out_ready = 0;
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    rst = 0;
    armed = 1;
    cyc();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_value", 64'(wb_value_out), 64'd0);

    // single beat pass-through
    out_ready = 1;
    drive(1, 1, 0, 32'h11, 32'h0, 4'd3);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("one_valid", 64'(out_valid), 64'd1);
    chk("one_value", 64'(wb_value_out), 64'h11);
    chk("one_dest", 64'(dest_out), 64'd3);
    cyc();
    chk("one_popped", 64'(out_valid), 64'd0);

    // backpressure fills buffer, third beat refused
    out_ready = 0;
    drive(1, 1, 0, 32'hA, 32'h0, 4'd1);
    cyc();
    chk("bp_ready1", 64'(in_ready), 64'd1);
    drive(1, 1, 0, 32'hB, 32'h0, 4'd2);
    cyc();
    chk("bp_full", 64'(in_ready), 64'd0);
    drive(1, 1, 0, 32'hC, 32'h0, 4'd4);
    cyc();
    chk("bp_hold", 64'(wb_value_out), 64'hA);
    drive(0, 0, 0, 0, 0, 0);
    out_ready = 1;
    cyc();
    chk("bp_second", 64'(wb_value_out), 64'hB);
    cyc();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // full with push and pop together: only the pop happens
    out_ready = 0;
    drive(1, 1, 0, 32'h1, 32'h0, 4'd1);
    cyc();
    drive(1, 1, 0, 32'h2, 32'h0, 4'd2);
    cyc();
    drive(1, 1, 0, 32'h3, 32'h0, 4'd3);
    out_ready = 1;
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("fpp_ready", 64'(in_ready), 64'd1);
    chk("fpp_head", 64'(wb_value_out), 64'h2);
    cyc();
    chk("fpp_no3", 64'(out_valid), 64'd0);

    // flush drops buffered entries and the incoming beat
    out_ready = 0;
    drive(1, 1, 0, 32'h21, 32'h0, 4'd1);
    cyc();
    drive(1, 1, 0, 32'h22, 32'h0, 4'd2);
    cyc();
    drive(1, 1, 0, 32'h23, 32'h0, 4'd3);
    flush = 1;
    out_ready = 1;
    cyc();
    flush = 0;
    drive(0, 0, 0, 0, 0, 0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    cyc();
    chk("fl_absent", 64'(out_valid), 64'd0);

    // memory-read select and wb_en=0 delivery
    out_ready = 0;
    drive(1, 1, 1, 32'h99, 32'h55, 4'd7);
    cyc();
    drive(1, 0, 1, 32'h98, 32'h66, 4'd5);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("mr_value", 64'(wb_value_out), 64'h55);
    chk("mr_alu", 64'(alu_res_out), 64'h99);
`ifdef MEM_WB_FWD_EN
    chk("fwd_v1", 64'(fwd_valid), 64'd1);
    chk("fwd_d1", 64'(fwd_dest), 64'd7);
    chk("fwd_val1", 64'(fwd_value), 64'h55);
`endif
    out_ready = 1;
    cyc();
    out_ready = 0;
    chk("nowb_valid", 64'(out_valid), 64'd1);
    chk("nowb_wb", 64'(wb_en_out), 64'd0);
    chk("nowb_value", 64'(wb_value_out), 64'h66);
`ifdef MEM_WB_FWD_EN
    chk("fwd_v0", 64'(fwd_valid), 64'd0);
    chk("fwd_d0", 64'(fwd_dest), 64'd0);
    chk("fwd_val0", 64'(fwd_value), 64'd0);
`endif

    // reset mid-transfer discards all entries
    drive(1, 1, 0, 32'h77, 32'h0, 4'd9);
    rst = 1;
    flush = 1;
    cyc();
    rst = 0;
    flush = 0;
    drive(0, 0, 0, 0, 0, 0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);

    // mixed traffic exercises pointer wrap
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom, $urandom,
            4'($urandom_range(0, 15)));
      out_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 15) == 0);
      cyc();
    end
    flush = 0;
    drive(0, 0, 0, 0, 0, 0);
    out_ready = 1;
    repeat (4) cyc();
    chk("drain_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_buffered_reg.md
MEM_WB_BUFFERED_REG -- requirements
Module: mem_wb_buffered_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of ALU and memory result fields.
REQ-002 SHALL have parameter ADDR_W, default 4, width of destination register address.
REQ-003 SHALL have parameter DEPTH, default 2, number of buffered entries; power of two, minimum 2.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1, rising-edge clock.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port flush, input, 1, synchronous discard of all buffered entries.
REQ-008 Port in_valid / in_ready, input / output, 1 / 1, upstream MEM-stage handshake.
REQ-009 Port wb_en_in, mem_r_in, input, 1 each, write-back enable and memory-read flag.
REQ-010 Port alu_res_in, mem_res_in, input, DATA_W each, ALU result and memory read data.
REQ-011 Port dest_in, input, ADDR_W, destination register.
REQ-012 Port out_valid / out_ready, output / input, 1 / 1, downstream WB handshake.
REQ-013 Port wb_en_out, mem_r_out, alu_res_out, mem_res_out, dest_out, output, mirroring input widths, head-entry fields.
REQ-014 Port wb_value_out, output, DATA_W, mem_res_out when mem_r_out=1, else alu_res_out.

Function
REQ-015 SHALL hold entries in a circular buffer with read/write pointers of width log2(DEPTH) and an occupancy count of width log2(DEPTH+1).
REQ-016 in_ready SHALL be 1 exactly when count < DEPTH; it SHALL NOT depend combinationally on out_ready.
REQ-017 out_valid SHALL be 1 exactly when count != 0.
REQ-018 Push SHALL occur on a rising edge when in_valid & in_ready & !flush; pop when out_valid & out_ready & !flush.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-020 Latency SHALL be one cycle: an entry pushed into an empty buffer at edge N is visible on outputs after edge N; no combinational path from any *_in port to any *_out port.
REQ-021 Output fields SHALL present the head entry while out_valid=1 and SHALL be all zero while out_valid=0.
REQ-022 Output fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 Entries with wb_en_in=0 SHALL be buffered and delivered like any other entry.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 flush SHALL set count and both pointers to 0 on the edge it is sampled, overriding any same-cycle push or pop; the incoming beat is dropped.
REQ-026 Entries SHALL be delivered in push order, with no loss or duplication outside flush.

Reset
REQ-027 On rst=1 at a rising edge, count, read and write pointers SHALL become 0; rst SHALL override flush, push and pop.
REQ-028 After reset, out_valid=0, in_ready=1, and all data outputs SHALL be 0; storage array contents need no reset.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered entries.

Configuration
REQ-030 Macro MEM_WB_FWD_EN SHALL, when defined, add outputs fwd_valid (1), fwd_dest (ADDR_W), fwd_value (DATA_W).
REQ-031 With MEM_WB_FWD_EN, fwd_valid SHALL equal out_valid & wb_en_out, fwd_dest SHALL equal dest_out, and fwd_value SHALL equal wb_value_out; all three SHALL be 0 when fwd_valid=0.
REQ-032 Without MEM_WB_FWD_EN, these ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 Field-width constants and the packed-entry width (2 + 2*DATA_W + ADDR_W) SHALL reside in the shared constants header.
REQ-034 Storage SHALL be a sub-module named stage_buf_mem (write port and read port, no reset); pointer and count control SHALL stay in the top module.

Verification
REQ-035 Reset then idle -> out_valid=0, in_ready=1, wb_value_out=0.
REQ-036 Push alu=0x11, mem_r=0, dest=3 with out_ready=1 -> next cycle out_valid=1, wb_value_out=0x11, dest_out=3; popped the following edge.
REQ-037 out_ready=0, push 0xA, 0xB -> in_ready=0 after the second push; third beat not accepted; release out_ready -> 0xA then 0xB delivered in order.
REQ-038 Buffer full, push and pop asserted together -> in_ready=0, no push, one pop, count becomes 1.
REQ-039 Two entries buffered, flush=1 with in_valid=1 -> next cycle out_valid=0, count=0, incoming beat absent.
REQ-040 With MEM_WB_FWD_EN, head entry mem_r=1, mem_res=0x55, wb_en=1, dest=7 -> fwd_valid=1, fwd_dest=7, fwd_value=0x55; with wb_en=0 -> fwd_valid=0, fwd_dest=0, fwd_value=0.
